// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter: FSM state encodings
// and the hard-wired zero register constant.
package regfile_wr_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_WAIT  = 2'd1,
    ARB_FORCE = 2'd2
  } arb_state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  function automatic logic is_x0(input logic [4:0] addr);
    return addr == REG_X0;
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Bundle of WB, M-unit, issue, hazard-query and register-file signals around
// the write-port arbiter. Perf counter signals exist only with RFARB_PERF_CNT_EN.
interface regfile_wr_arbiter_if #(
  parameter int XLEN = 32
);
  logic            wb_en;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;

  // M-unit handshake: a result transfers in any cycle where md_valid and
  // md_ready are both high; md_ready never depends on md_valid.
  logic            md_valid;
  logic            md_ready;
  logic [4:0]      md_addr;
  logic [XLEN-1:0] md_data;

  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic            rs1_pending;
  logic            rs2_pending;

  logic            wb_hold;
  logic            reg_file_wr_en;
  logic [4:0]      reg_file_wr_addr;
  logic [XLEN-1:0] reg_file_wr_data;

  regfile_wr_arbiter_pkg::arb_state_e dbg_state;

`ifdef RFARB_PERF_CNT_EN
  logic [31:0]     perf_conflict_cnt;
  logic [31:0]     perf_hold_cnt;
`endif

  modport master (
`ifdef RFARB_PERF_CNT_EN
    input  perf_conflict_cnt, perf_hold_cnt,
`endif
    output wb_en, wb_addr, wb_data,
    output md_valid, md_addr, md_data,
    output issue_valid, issue_rd, rs1_addr, rs2_addr,
    input  md_ready, rs1_pending, rs2_pending, wb_hold,
    input  reg_file_wr_en, reg_file_wr_addr, reg_file_wr_data,
    input  dbg_state
  );

  modport slave (
`ifdef RFARB_PERF_CNT_EN
    output perf_conflict_cnt, perf_hold_cnt,
`endif
    input  wb_en, wb_addr, wb_data,
    input  md_valid, md_addr, md_data,
    input  issue_valid, issue_rd, rs1_addr, rs2_addr,
    output md_ready, rs1_pending, rs2_pending, wb_hold,
    output reg_file_wr_en, reg_file_wr_addr, reg_file_wr_data,
    output dbg_state
  );

endinterface

// File: rtl/regfile_wr_arbiter_fifo.sv
// rfarb_fifo: small synchronous FIFO for deferred M-unit results. The caller
// never pushes when full nor pops when empty; DEPTH must be a power of two.
module rfarb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q;
  logic [AW-1:0]    wr_q;
  logic [AW:0]      cnt_q;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_q];
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: WB first, then buffered M results, then direct
// M pass-through; pending scoreboard and starvation FSM. Optional RFARB_PERF_CNT_EN.
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_WAIT   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wr_arbiter_if.slave  bus
);
  localparam int EW = 5 + XLEN;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);

  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic [EW-1:0]   fifo_head;
  logic [4:0]      head_addr;
  logic [XLEN-1:0] head_data;

  logic wb_act, md_acc, pop, direct, push, blocked, will_empty;

  logic [31:0] pending_q, pending_d;
  logic        clr_en;
  logic [4:0]  clr_addr;

  arb_state_e  state_q;
  logic [WW-1:0] wait_q;
  logic        hold_q;

  rfarb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({bus.md_addr, bus.md_data}),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign {head_addr, head_data} = fifo_head;

  // A WB write to x0 is dropped, which leaves the port free for M results.
  assign wb_act     = bus.wb_en && !is_x0(bus.wb_addr);
  assign bus.md_ready = !fifo_full;
  assign md_acc     = bus.md_valid && !fifo_full;
  assign pop        = !wb_act && !fifo_empty;
  assign direct     = !wb_act && fifo_empty && md_acc;
  assign push       = md_acc && !direct;
  assign blocked    = wb_act && !fifo_empty;
  assign will_empty = pop && !push && (fifo_count == CW'(1));

  always_comb begin
    bus.reg_file_wr_en   = 1'b0;
    bus.reg_file_wr_addr = '0;
    bus.reg_file_wr_data = '0;
    if (wb_act) begin
      bus.reg_file_wr_en   = 1'b1;
      bus.reg_file_wr_addr = bus.wb_addr;
      bus.reg_file_wr_data = bus.wb_data;
    end else if (pop) begin
      bus.reg_file_wr_en   = !is_x0(head_addr);
      bus.reg_file_wr_addr = head_addr;
      bus.reg_file_wr_data = head_data;
    end else if (direct) begin
      bus.reg_file_wr_en   = !is_x0(bus.md_addr);
      bus.reg_file_wr_addr = bus.md_addr;
      bus.reg_file_wr_data = bus.md_data;
    end
  end

  // Set after clear so a same-cycle re-issue of the committing register wins.
  assign clr_en   = pop || direct;
  assign clr_addr = pop ? head_addr : bus.md_addr;

  always_comb begin
    pending_d = pending_q;
    if (clr_en)          pending_d[clr_addr]     = 1'b0;
    if (bus.issue_valid) pending_d[bus.issue_rd] = 1'b1;
    pending_d[REG_X0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pending_q <= '0;
    else      pending_q <= pending_d;
  end

  assign bus.rs1_pending = pending_q[bus.rs1_addr];
  assign bus.rs2_pending = pending_q[bus.rs2_addr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      wait_q  <= '0;
      hold_q  <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (push) begin
            state_q <= ARB_WAIT;
            wait_q  <= '0;
          end
        end
        ARB_WAIT: begin
          if (will_empty) begin
            state_q <= ARB_IDLE;
            wait_q  <= '0;
          end else if (pop) begin
            wait_q <= '0;
          end else if (blocked) begin
            if (wait_q == WW'(MAX_WAIT - 1)) begin
              state_q <= ARB_FORCE;
              hold_q  <= 1'b1;
              wait_q  <= WW'(MAX_WAIT);
            end else begin
              wait_q <= wait_q + 1'b1;
            end
          end
        end
        ARB_FORCE: begin
          if (pop) begin
            state_q <= will_empty ? ARB_IDLE : ARB_WAIT;
            wait_q  <= '0;
            hold_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ARB_IDLE;
          wait_q  <= '0;
          hold_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wb_hold   = hold_q;
  assign bus.dbg_state = state_q;

`ifdef RFARB_PERF_CNT_EN
  logic [31:0] conflict_cnt_q, hold_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_cnt_q <= '0;
      hold_cnt_q     <= '0;
    end else begin
      if ((!fifo_empty || bus.md_valid) && wb_act && (conflict_cnt_q != '1))
        conflict_cnt_q <= conflict_cnt_q + 32'd1;
      if (hold_q && (hold_cnt_q != '1))
        hold_cnt_q <= hold_cnt_q + 32'd1;
    end
  end

  assign bus.perf_conflict_cnt = conflict_cnt_q;
  assign bus.perf_hold_cnt     = hold_cnt_q;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios plus random
// traffic against a queue-based reference model. Perf checks with RFARB_PERF_CNT_EN.
module tb_regfile_wr_arbiter;
  import regfile_wr_arbiter_pkg::*;

  localparam int XLEN     = 32;
  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  regfile_wr_arbiter_if #(.XLEN(XLEN)) bus ();

  regfile_wr_arbiter #(
    .XLEN       (XLEN),
    .FIFO_DEPTH (DEPTH),
    .MAX_WAIT   (MAX_WAIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: pending M results in arrival order, per-register pending
  // flags, and the starvation rule as "blocked cycles since last drain".
  logic [XLEN+4:0] exp_q[$];
  bit              pend[32];
  int              blocked_run;
  bit              hold_exp;
  longint          conf_exp, hold_cnt_exp;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < 32; i++) pend[i] = 1'b0;
    blocked_run  = 0;
    hold_exp     = 1'b0;
    conf_exp     = 0;
    hold_cnt_exp = 0;
  endtask

  task automatic set_in(input bit wb_en, input logic [4:0] wb_addr, input logic [XLEN-1:0] wb_data,
                        input bit md_valid, input logic [4:0] md_addr, input logic [XLEN-1:0] md_data,
                        input bit iv, input logic [4:0] ird, input logic [4:0] rs1, input logic [4:0] rs2);
    bus.wb_en       = wb_en;
    bus.wb_addr     = wb_addr;
    bus.wb_data     = wb_data;
    bus.md_valid    = md_valid;
    bus.md_addr     = md_addr;
    bus.md_data     = md_data;
    bus.issue_valid = iv;
    bus.issue_rd    = ird;
    bus.rs1_addr    = rs1;
    bus.rs2_addr    = rs2;
  endtask

  // One clock: compare DUT outputs against the model at the falling edge,
  // then advance the model to the state after the next rising edge.
  task automatic step();
    logic [XLEN+4:0] head;
    bit wb_act, mrdy, pop, direct, push, en, clr, blocked;
    logic [4:0] a, ca;
    logic [XLEN-1:0] d;
    arb_state_e st;
    @(negedge clk);
    mrdy   = (exp_q.size() < DEPTH);
    wb_act = bus.wb_en && (bus.wb_addr != 5'd0);
    pop = 0; direct = 0; clr = 0; en = 0; a = '0; d = '0; ca = '0;
    if (wb_act) begin
      en = 1; a = bus.wb_addr; d = bus.wb_data;
    end else if (exp_q.size() > 0) begin
      pop = 1; head = exp_q[0]; ca = head[XLEN+4:XLEN]; a = ca; d = head[XLEN-1:0];
      en = (ca != 5'd0); clr = 1;
    end else if (bus.md_valid && mrdy) begin
      direct = 1; ca = bus.md_addr; a = ca; d = bus.md_data; en = (ca != 5'd0); clr = 1;
    end
    push = bus.md_valid && mrdy && !direct;
    st = hold_exp ? ARB_FORCE : ((exp_q.size() > 0) ? ARB_WAIT : ARB_IDLE);

    check_val("wr_en",       64'(bus.reg_file_wr_en), 64'(en));
    if (en) begin
      check_val("wr_addr",   64'(bus.reg_file_wr_addr), 64'(a));
      check_val("wr_data",   64'(bus.reg_file_wr_data), 64'(d));
    end
    check_val("md_ready",    64'(bus.md_ready), 64'(mrdy));
    check_val("wb_hold",     64'(bus.wb_hold), 64'(hold_exp));
    check_val("rs1_pending", 64'(bus.rs1_pending), 64'(pend[bus.rs1_addr]));
    check_val("rs2_pending", 64'(bus.rs2_pending), 64'(pend[bus.rs2_addr]));
    check_val("state",       64'(bus.dbg_state), 64'(st));
`ifdef RFARB_PERF_CNT_EN
    check_val("perf_conflict", 64'(bus.perf_conflict_cnt), 64'(conf_exp));
    check_val("perf_hold",     64'(bus.perf_hold_cnt), 64'(hold_cnt_exp));
`endif
    if (((exp_q.size() > 0) || bus.md_valid) && wb_act) conf_exp++;
    if (hold_exp) hold_cnt_exp++;

    blocked = (exp_q.size() > 0) && wb_act;
    if (clr) pend[ca] = 1'b0;
    if (bus.issue_valid && bus.issue_rd != 5'd0) pend[bus.issue_rd] = 1'b1;
    if (pop) begin
      void'(exp_q.pop_front());
      blocked_run = 0;
      hold_exp    = 1'b0;
    end else if (blocked && !hold_exp) begin
      blocked_run++;
      if (blocked_run >= MAX_WAIT) hold_exp = 1'b1;
    end
    if (push) exp_q.push_back({bus.md_addr, bus.md_data});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    model_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check_val("rst_md_ready", 64'(bus.md_ready), 64'd1);
    check_val("rst_wb_hold",  64'(bus.wb_hold), 64'd0);
    check_val("rst_wr_en",    64'(bus.reg_file_wr_en), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // WB only, then a WB to x0 which must not write
    set_in(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check_val("wb_only_data", 64'(bus.reg_file_wr_data), 64'hDEADBEEF);
    step();
    set_in(1, 0, 32'h55, 0, 0, 0, 0, 0, 0, 0);
    step();

    // Direct pass-through of x7 clears its pending flag
    set_in(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    step();
    set_in(0, 0, 0, 1, 7, 32'h12, 0, 0, 7, 0);
    #1;
    check_val("x7_pending_before", 64'(bus.rs1_pending), 64'd1);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 7, 7);
    step();

    // Conflict: two M results buffered behind WB, then drained in order
    set_in(1, 1, 32'hA0, 1, 3, 32'hAAAA, 0, 0, 3, 4);
    step();
    set_in(1, 2, 32'hB0, 1, 4, 32'hBBBB, 0, 0, 3, 4);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 3, 4);
    #1;
    check_val("full_md_ready", 64'(bus.md_ready), 64'd0);
    check_val("drain_x3", 64'(bus.reg_file_wr_addr), 64'd3);
    step();
    step();

    // Scoreboard: re-issue of x9 in the commit cycle keeps it pending
    set_in(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    step();
    set_in(0, 0, 0, 1, 9, 32'h99, 1, 9, 9, 0);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
    #1;
    check_val("x9_still_pending", 64'(bus.rs1_pending), 64'd1);
    step();

    // Starvation into FORCE with two buffered entries, then async reset
    set_in(1, 1, 32'h1, 1, 3, 32'h33, 1, 3, 3, 4);
    step();
    set_in(1, 1, 32'h1, 1, 4, 32'h44, 1, 4, 3, 4);
    step();
    set_in(1, 1, 32'h1, 0, 0, 0, 0, 0, 3, 4);
    repeat (3) step();
    check_val("hold_before_rst", 64'(bus.wb_hold), 64'd1);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 3, 4);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_val("arst_md_ready", 64'(bus.md_ready), 64'd1);
    check_val("arst_wb_hold",  64'(bus.wb_hold), 64'd0);
    check_val("arst_wr_en",    64'(bus.reg_file_wr_en), 64'd0);
    check_val("arst_state",    64'(bus.dbg_state), 64'(ARB_IDLE));
    for (int i = 0; i < 16; i++) begin
      bus.rs1_addr = 5'(i);
      bus.rs2_addr = 5'(i + 16);
      #1;
      check_val("arst_pend_rs1", 64'(bus.rs1_pending), 64'd0);
      check_val("arst_pend_rs2", 64'(bus.rs2_pending), 64'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Random traffic: heavy WB phase stresses starvation, lighter phase drains
    for (int c = 0; c < 3000; c++) begin
      int wb_pct;
      wb_pct = (c < 1500) ? 85 : 40;
      set_in($urandom_range(0, 99) < wb_pct, 5'($urandom_range(0, 7)), $urandom,
             $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
             $urandom_range(0, 9) < 3, 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the single register-file write port (reg_file_wr_en/addr/data into decode_stage) between two requesters: the in-order WB stage and the multi-cycle M-extension (mul/div) unit.
- WB always wins. Deferred M-unit results are buffered in a small FIFO.
- A starvation FSM requests a WB bubble so buffered results cannot wait forever.
- Holds a per-register pending scoreboard for in-flight M-unit destinations, which the hazard unit uses to stall dependents.

Parameters:
- XLEN, 32, data width
- FIFO_DEPTH, 2, M-result buffer entries (power of two, >=2)
- MAX_WAIT, 4, consecutive blocked cycles before wb_hold asserts (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- wb_en  in  1  WB-stage write request
- wb_addr  in  5  WB destination
- wb_data  in  XLEN  WB data
- md_valid  in  1  M-unit result valid
- md_ready  out  1  arbiter can accept M result
- md_addr  in  5  M-unit destination
- md_data  in  XLEN  M-unit result
- issue_valid  in  1  M instruction leaves decode (m_type_inst, not flushed)
- issue_rd  in  5  its rd
- rs1_addr  in  5  decode rs1
- rs2_addr  in  5  decode rs2
- rs1_pending  out  1  rs1 awaits an M result
- rs2_pending  out  1  rs2 awaits an M result
- wb_hold  out  1  request pipeline to insert a WB bubble next cycle
- reg_file_wr_en  out  1  to register file
- reg_file_wr_addr  out  5  to register file
- reg_file_wr_data  out  XLEN  to register file

Behaviour:
- Reset (rst=0, async): FIFO empty; pending = 0; wait counter = 0; FSM IDLE; wb_hold = 0; md_ready = 1; reg_file_wr_en = 0.
- Write port is combinational, with no added latency. Priority: WB > FIFO head > direct M pass-through.
- WB with wb_addr=0 is dropped, and the port counts as free that cycle.
- Port free and FIFO non-empty: head is written and popped.
- Port free, FIFO empty, md_valid & md_ready: M result is written directly and not stored.
- Otherwise an accepted M result is pushed to the FIFO.
- An M result with addr 0 is consumed (popped or accepted) but not written.
- md_ready = !full, derived from the registered count only. A same-cycle pop does not raise md_ready.
- Push and pop in the same cycle keep the count unchanged. FIFO order is strict.
- Scoreboard:
  - issue_valid sets pending[issue_rd] (ignored when issue_rd=0).
  - pending[a] clears when an M write to a commits or is dropped.
  - Same-cycle set and clear of the same register: set wins.
  - rs*_pending = pending[rs*_addr], combinational, with no bypass of a same-cycle clear.
- FSM:
  - IDLE: FIFO empty. Goes to WAIT on a push.
  - WAIT: counter increments each cycle the head is blocked by WB and resets to 0 on each pop. Count reaching MAX_WAIT goes to FORCE. FIFO becoming empty goes to IDLE.
  - FORCE: wb_hold = 1 (registered). Goes to WAIT (counter 0) on the first pop, or to IDLE if the FIFO then empties.
  - wb_hold = 0 in IDLE and WAIT.

Optional Feature:
- Macro RFARB_PERF_CNT_EN.
- Defined: adds outputs perf_conflict_cnt (32) and perf_hold_cnt (32).
  - perf_conflict_cnt increments on cycles where an M result is present (FIFO non-empty or md_valid) and WB owns the port.
  - perf_hold_cnt increments on cycles with wb_hold=1.
  - Both saturate at all-ones and reset to 0.
- Undefined: neither the ports nor the counters exist, and all other behaviour is identical.

Decomposition:
- Shared package/defines.vh: FSM state encodings (ARB_IDLE, ARB_WAIT, ARB_FORCE) and the REG_X0 constant.
- One sub-module: rfarb_fifo (synchronous FIFO, parameters DEPTH and WIDTH = 5+XLEN, with push/pop/full/empty/head outputs).
- Scoreboard and FSM stay in the top module.

Test Plan:
- Only WB: wb_en=1, wb_addr=5, wb_data=0xDEADBEEF -> same-cycle wr_en=1, addr=5, data=0xDEADBEEF. wb_addr=0 -> wr_en=0.
- Direct pass: FIFO empty, wb_en=0, md_valid=1, md_addr=7, md_data=0x12 -> same-cycle write of x7=0x12. FIFO stays empty, and pending[7] clears.
- Conflict and buffer: WB busy 2 cycles while M results A (x3) and B (x4) arrive -> md_ready=0 after 2 pushes. When WB idles, x3 then x4 are written in consecutive cycles.
- Starvation: WB busy continuously with FIFO non-empty, MAX_WAIT=4 -> wb_hold rises after 4 blocked cycles. Once WB drops, the head pops and wb_hold falls the next cycle.
- Scoreboard: issue_valid, issue_rd=9 -> rs1_addr=9 gives rs1_pending=1 until the x9 M write commits. issue_valid for x9 in the same cycle as that commit -> pending stays 1.
- Reset mid-operation: FIFO holding 2 entries and state FORCE, assert rst -> immediately empty, wb_hold=0, md_ready=1, all pending=0.
